// File: rtl/audio_mix_scheduler.sv
// Time-multiplexed stereo mixer: snapshots all sources once per sample period and
// sequences them through one shared saturating adder into left/right accumulators.
module audio_mix_scheduler #(
   parameter int SAMPLE_DIV   = 875,
   parameter bit USE_EXT_TICK = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ext_tick,
   input  logic [7:0]  mixer,
   input  logic [7:0]  ay1_cha,
   input  logic [7:0]  ay1_chb,
   input  logic [7:0]  ay1_chc,
   input  logic [7:0]  ay2_cha,
   input  logic [7:0]  ay2_chb,
   input  logic [7:0]  ay2_chc,
   input  logic [7:0]  beeper,
   input  logic [7:0]  specdrum,
   input  logic [15:0] midi_left,
   input  logic [15:0] midi_right,
   output logic [8:0]  left,
   output logic [8:0]  right,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

   generate
      if (SAMPLE_DIV < 12) begin : g_bad_div
         $error("audio_mix_scheduler: SAMPLE_DIV must be >= 12");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    step_q, step_d;
   logic [DW-1:0] div_q, div_d;
   logic [11:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [7:0]    a1a_q, a1a_d, a1b_q, a1b_d, a1c_q, a1c_d;
   logic [7:0]    a2a_q, a2a_d, a2b_q, a2b_d, a2c_q, a2c_d;
   logic [7:0]    bp_q, bp_d, sd_q, sd_d, mix_q, mix_d;
   logic [15:0]   ml_q, ml_d, mr_q, mr_d;
   logic [8:0]    left_q, left_d, right_q, right_d;
   logic          valid_q, valid_d, ovr_q, ovr_d;

   logic          start_s, busy_s;
   logic [10:0]   term_l_s, term_r_s;
   logic [1:0]    pan_s;
   logic [11:0]   sum_l_s, sum_r_s;

   // Adds clamp at 12-bit full scale so very loud mixes still read as saturated.
   function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [10:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {2'b00, b};
      sat_add = s[12] ? 12'hFFF : s[11:0];
   endfunction

   function automatic logic [8:0] dac_word(input logic [11:0] acc);
      dac_word = acc[11] ? 9'h1FF : acc[10:2];
   endfunction

   function automatic logic [10:0] midi_term(input logic [15:0] m);
      midi_term = m[15:5] ^ 11'h400;
   endfunction

   assign busy_s  = (state_q != S_IDLE);
   assign start_s = USE_EXT_TICK ? (ext_tick & en) : (en & (div_q == DIV_LAST));

   always_comb begin
      term_l_s = 11'd0;
      term_r_s = 11'd0;
      pan_s    = 2'b00;
      case (step_q)
         4'd0: begin term_l_s = {3'b000, a1a_q}; term_r_s = term_l_s; pan_s = mix_q[7:6]; end
         4'd1: begin term_l_s = {3'b000, a1b_q}; term_r_s = term_l_s; pan_s = mix_q[5:4]; end
         4'd2: begin term_l_s = {3'b000, a1c_q}; term_r_s = term_l_s; pan_s = mix_q[3:2]; end
         4'd3: begin term_l_s = {3'b000, a2a_q}; term_r_s = term_l_s; pan_s = mix_q[7:6]; end
         4'd4: begin term_l_s = {3'b000, a2b_q}; term_r_s = term_l_s; pan_s = mix_q[5:4]; end
         4'd5: begin term_l_s = {3'b000, a2c_q}; term_r_s = term_l_s; pan_s = mix_q[3:2]; end
         4'd6: begin term_l_s = {3'b000, bp_q};  term_r_s = term_l_s; pan_s = mix_q[1:0]; end
         4'd7: begin term_l_s = {2'b00, sd_q, sd_q[7]}; term_r_s = term_l_s; pan_s = mix_q[1:0]; end
         4'd8: begin term_l_s = midi_term(ml_q); term_r_s = midi_term(mr_q); pan_s = mix_q[1:0]; end
         default: begin term_l_s = 11'd0; term_r_s = 11'd0; pan_s = 2'b00; end
      endcase
      sum_l_s = pan_s[1] ? sat_add(acc_l_q, term_l_s) : acc_l_q;
      sum_r_s = pan_s[0] ? sat_add(acc_r_q, term_r_s) : acc_r_q;
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      a1a_d = a1a_q; a1b_d = a1b_q; a1c_d = a1c_q;
      a2a_d = a2a_q; a2b_d = a2b_q; a2c_d = a2c_q;
      bp_d  = bp_q;  sd_d  = sd_q;  mix_d = mix_q;
      ml_d  = ml_q;  mr_d  = mr_q;
      left_d  = left_q;
      right_d = right_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q | (start_s & busy_s);

      if (!en) begin
         div_d = '0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
      end else begin
         div_d = div_q + DW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            a1a_d = ay1_cha; a1b_d = ay1_chb; a1c_d = ay1_chc;
            a2a_d = ay2_cha; a2b_d = ay2_chb; a2c_d = ay2_chc;
            bp_d  = beeper;  sd_d  = specdrum; mix_d = mixer;
            ml_d  = midi_left; mr_d = midi_right;
            acc_l_d = 12'd0;
            acc_r_d = 12'd0;
            step_d  = 4'd0;
            state_d = S_ACC;
         end
         S_ACC: begin
            acc_l_d = sum_l_s;
            acc_r_d = sum_r_s;
            // Outputs are registered off the final sum so they appear during DONE.
            if (step_q == 4'd8) begin
               left_d  = dac_word(sum_l_s);
               right_d = dac_word(sum_r_s);
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= 4'd0;
         div_q   <= '0;
         acc_l_q <= 12'd0;
         acc_r_q <= 12'd0;
         a1a_q <= 8'd0; a1b_q <= 8'd0; a1c_q <= 8'd0;
         a2a_q <= 8'd0; a2b_q <= 8'd0; a2c_q <= 8'd0;
         bp_q  <= 8'd0; sd_q  <= 8'd0; mix_q <= 8'd0;
         ml_q  <= 16'd0; mr_q <= 16'd0;
         left_q  <= 9'd0;
         right_q <= 9'd0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         div_q   <= div_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         a1a_q <= a1a_d; a1b_q <= a1b_d; a1c_q <= a1c_d;
         a2a_q <= a2a_d; a2b_q <= a2b_d; a2c_q <= a2c_d;
         bp_q  <= bp_d;  sd_q  <= sd_d;  mix_q <= mix_d;
         ml_q  <= ml_d;  mr_q  <= mr_d;
         left_q  <= left_d;
         right_q <= right_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign left         = left_q;
   assign right        = right_q;
   assign sample_valid = valid_q;
   assign busy         = busy_s;
   assign overrun      = ovr_q;

endmodule
